// File: rtl/assoc_cache_controller.sv
// Set-associative write-through cache sitting between the MEM stage and an SRAM controller.
// Misses fill a whole two-word line; stores go straight to SRAM and only update a line that is already cached.
module assoc_cache_controller #(
  parameter int WAYS = 2,
  parameter int SETS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic [31:0] read_data,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic        sram_ready,
  input  logic [63:0] sram_read_data,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 29 - IDX_W;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state_q, state_d, cur_state;

  logic [SETS-1:0]  valid_q [WAYS];
  logic [SETS-1:0]  valid_d [WAYS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [TAG_W-1:0] tag_d   [WAYS][SETS];
  logic [31:0]      data_q  [WAYS][SETS][2];
  logic [31:0]      data_d  [WAYS][SETS][2];
  logic [AGE_W-1:0] age_q   [WAYS][SETS];
  logic [AGE_W-1:0] age_d   [WAYS][SETS];
  logic [15:0]      hit_q, hit_d, miss_q, miss_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             word_sel;
  logic             unused_addr_bits;

  logic             hit;
  logic             victim_found;
  logic             age_upd;
  logic [AGE_W-1:0] hit_way, victim_way, acc_way;

  assign idx              = address[3 +: IDX_W];
  assign tag              = address[31 -: TAG_W];
  assign word_sel         = address[2];
  assign unused_addr_bits = ^address[1:0];

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Lines are treated as invalid while rst is held so outputs follow the post-reset view.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rst && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  always_comb begin
    victim_found = 1'b0;
    victim_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[w][idx]) begin
        victim_found = 1'b1;
        victim_way   = AGE_W'(w);
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][idx] > age_q[victim_way][idx]) begin
          victim_way = AGE_W'(w);
        end
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    tag_d           = tag_q;
    data_d          = data_q;
    age_d           = age_q;
    hit_d           = hit_q;
    miss_d          = miss_q;
    ready           = 1'b0;
    read_data       = '0;
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    sram_address    = '0;
    sram_write_data = '0;
    age_upd         = 1'b0;
    acc_way         = '0;
    cur_state       = rst ? IDLE : state_q;

    case (cur_state)
      IDLE: begin
        if (mem_write_en) begin
          state_d = WRITE;
        end else if (mem_read_en) begin
          if (hit) begin
            ready     = 1'b1;
            read_data = data_q[hit_way][idx][word_sel];
            age_upd   = 1'b1;
            acc_way   = hit_way;
            if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
          end else begin
            state_d = FILL;
            if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
          end
        end else begin
          ready = 1'b1;
        end
      end

      FILL: begin
        sram_read_en = 1'b1;
        sram_address = {address[31:3], 3'b000};
        if (sram_ready) begin
          ready                        = 1'b1;
          read_data                    = word_sel ? sram_read_data[63:32] : sram_read_data[31:0];
          valid_d[victim_way][idx]     = 1'b1;
          tag_d[victim_way][idx]       = tag;
          data_d[victim_way][idx][0]   = sram_read_data[31:0];
          data_d[victim_way][idx][1]   = sram_read_data[63:32];
          age_upd                      = 1'b1;
          acc_way                      = victim_way;
          state_d                      = IDLE;
        end
      end

      WRITE: begin
        sram_write_en   = 1'b1;
        sram_address    = address;
        sram_write_data = write_data;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
          if (hit) begin
            data_d[hit_way][idx][word_sel] = write_data;
            age_upd                        = 1'b1;
            acc_way                        = hit_way;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Ages within a set stay a permutation: the touched way becomes youngest.
    if (age_upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][idx] < age_q[acc_way][idx]) begin
          age_d[w][idx] = age_q[w][idx] + 1'b1;
        end
      end
      age_d[acc_way][idx] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hit_q   <= '0;
      miss_q  <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        for (int s = 0; s < SETS; s++) begin
          age_q[w][s] <= AGE_W'(w);
        end
      end
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Tag and data need no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Scoreboard bench for assoc_cache_controller (WAYS=2, SETS=64) with a small SRAM controller model.
// Directed requests push their expected completion; a monitor pops and compares on every ready.
module tb_assoc_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [31:0] address, write_data;
  logic        ready;
  logic [31:0] read_data;
  logic        sram_read_en, sram_write_en;
  logic [31:0] sram_address, sram_write_data;
  logic        sram_ready;
  logic [63:0] sram_read_data;
  logic [15:0] hit_count, miss_count;

  localparam int SRAM_WAIT = 2;

  typedef struct {
    string       name;
    bit          is_load;
    logic [31:0] data;
    int          cycles;
    int          kind;
    logic [31:0] saddr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] sram_mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;

  assoc_cache_controller #(.WAYS(2), .SETS(64)) dut (
    .clk(clk), .rst(rst),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .address(address), .write_data(write_data),
    .ready(ready), .read_data(read_data),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_ready(sram_ready), .sram_read_data(sram_read_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:3], 3'b000};
    if (sram_mem.exists(base)) return sram_mem[base];
    return {32'hD0000000 | (base + 32'd4), 32'hD0000000 | base};
  endfunction

  // SRAM controller model: waits SRAM_WAIT cycles of a held request, then strobes sram_ready.
  initial begin
    int          pend;
    logic [63:0] ln;
    pend           = 0;
    sram_ready     = 1'b0;
    sram_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      sram_ready = 1'b0;
      if (sram_read_en || sram_write_en) begin
        if (pend == SRAM_WAIT) begin
          pend = 0;
          ln   = line_of(sram_address);
          if (sram_write_en) begin
            if (sram_address[2]) ln[63:32] = sram_write_data;
            else                 ln[31:0]  = sram_write_data;
            sram_mem[{sram_address[31:3], 3'b000}] = ln;
          end
          sram_read_data = ln;
          sram_ready     = 1'b1;
        end else begin
          pend++;
        end
      end else begin
        pend = 0;
      end
    end
  end

  // Monitor: counts cycles per request and notes the first SRAM access it caused.
  initial begin
    int          cyc;
    int          kind;
    logic [31:0] saddr;
    exp_t        e;
    cyc   = 0;
    kind  = 0;
    saddr = '0;
    forever begin
      @(negedge clk);
      checkOutput("sram_exclusive", {31'b0, sram_read_en & sram_write_en}, 32'd0);
      if (rst || !(mem_read_en || mem_write_en)) begin
        cyc  = 0;
        kind = 0;
      end else begin
        cyc++;
        if (kind == 0 && sram_read_en) begin
          kind  = 1;
          saddr = sram_address;
        end else if (kind == 0 && sram_write_en) begin
          kind  = 2;
          saddr = sram_address;
        end
        if (ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_completion: got ready=1 expected no pending request");
          end else begin
            e = exp_q.pop_front();
            checkOutput({e.name, "_cycles"}, cyc, e.cycles);
            checkOutput({e.name, "_sram_kind"}, kind, e.kind);
            if (e.kind != 0) checkOutput({e.name, "_sram_addr"}, saddr, e.saddr);
            if (e.is_load)   checkOutput({e.name, "_data"}, read_data, e.data);
          end
          cyc  = 0;
          kind = 0;
        end
      end
    end
  end

  // kind: 0 = no SRAM access, 1 = line fill, 2 = SRAM write
  task automatic applyStimulus(input string name, input bit is_wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_data,
                               input int exp_cycles, input int exp_kind, input logic [31:0] exp_saddr);
    exp_t e;
    int   n;
    e.name    = name;
    e.is_load = !is_wr;
    e.data    = exp_data;
    e.cycles  = exp_cycles;
    e.kind    = exp_kind;
    e.saddr   = exp_saddr;
    exp_q.push_back(e);
    mem_write_en = is_wr;
    mem_read_en  = !is_wr;
    address      = addr;
    write_data   = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 60);
    if (!ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no ready after %0d cycles expected completion", name, n);
    end
    @(posedge clk);
    #1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
  endtask

  task automatic doReset();
    rst          = 1'b1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkIdle(input string name, input logic [15:0] exp_hits, input logic [15:0] exp_misses);
    @(negedge clk);
    checkOutput({name, "_ready"}, {31'b0, ready}, 32'd1);
    checkOutput({name, "_sram_rd"}, {31'b0, sram_read_en}, 32'd0);
    checkOutput({name, "_sram_wr"}, {31'b0, sram_write_en}, 32'd0);
    checkOutput({name, "_hits"}, {16'b0, hit_count}, {16'b0, exp_hits});
    checkOutput({name, "_misses"}, {16'b0, miss_count}, {16'b0, exp_misses});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got no end of test expected $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    address      = '0;
    write_data   = '0;
    sram_mem[32'h400] = 64'hBBBBBBBB_AAAAAAAA;

    doReset();
    checkIdle("reset", 16'd0, 16'd0);

    // Cold miss then same-line hit
    applyStimulus("ld400_miss", 1'b0, 32'h400, 32'h0, 32'hAAAAAAAA, 4, 1, 32'h400);
    applyStimulus("ld404_hit", 1'b0, 32'h404, 32'h0, 32'hBBBBBBBB, 1, 0, 32'h0);
    checkIdle("after_035", 16'd1, 16'd1);

    // Store hit updates the cached word; the following load needs no SRAM
    applyStimulus("st404", 1'b1, 32'h404, 32'h12345678, 32'h0, 4, 2, 32'h404);
    applyStimulus("ld404_after_st", 1'b0, 32'h404, 32'h0, 32'h12345678, 1, 0, 32'h0);
    checkIdle("after_037", 16'd2, 16'd1);

    // Store miss does not allocate
    applyStimulus("st800", 1'b1, 32'h800, 32'hCAFEF00D, 32'h0, 4, 2, 32'h800);
    applyStimulus("ld800_miss", 1'b0, 32'h800, 32'h0, 32'hCAFEF00D, 4, 1, 32'h800);
    checkIdle("after_038", 16'd2, 16'd2);

    // LRU replacement within set 0
    doReset();
    checkIdle("reset2", 16'd0, 16'd0);
    applyStimulus("lru_ld000_a", 1'b0, 32'h000, 32'h0, 32'hD0000000, 4, 1, 32'h000);
    applyStimulus("lru_ld200_a", 1'b0, 32'h200, 32'h0, 32'hD0000200, 4, 1, 32'h200);
    applyStimulus("lru_ld000_b", 1'b0, 32'h000, 32'h0, 32'hD0000000, 1, 0, 32'h0);
    applyStimulus("lru_ld400", 1'b0, 32'h400, 32'h0, 32'hAAAAAAAA, 4, 1, 32'h400);
    applyStimulus("lru_ld000_c", 1'b0, 32'h000, 32'h0, 32'hD0000000, 1, 0, 32'h0);
    applyStimulus("lru_ld200_b", 1'b0, 32'h200, 32'h0, 32'hD0000200, 4, 1, 32'h200);
    checkIdle("after_036", 16'd2, 16'd4);

    // Reset in the middle of a fill
    mem_read_en = 1'b1;
    address     = 32'h400;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("midfill_rd_en", {31'b0, sram_read_en}, 32'd1);
    checkOutput("midfill_addr", sram_address, 32'h400);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_held_rd_en", {31'b0, sram_read_en}, 32'd0);
    checkOutput("rst_held_ready", {31'b0, ready}, 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    mem_read_en = 1'b0;
    checkIdle("after_rst_fill", 16'd0, 16'd0);
    applyStimulus("ld400_after_rst", 1'b0, 32'h400, 32'h0, 32'hAAAAAAAA, 4, 1, 32'h400);

    // Hit counter saturation
    for (int i = 0; i < 65535; i++) begin
      applyStimulus("sat_hit", 1'b0, 32'h400, 32'h0, 32'hAAAAAAAA, 1, 0, 32'h0);
    end
    checkIdle("hits_at_max", 16'hFFFF, 16'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("sat_hit_extra", 1'b0, 32'h400, 32'h0, 32'hAAAAAAAA, 1, 0, 32'h0);
    end
    checkIdle("hits_saturated", 16'hFFFF, 16'd1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
